// File: rtl/write_buffer.sv
// Posted write buffer between a cache and main memory: a circular FIFO of {addr, data}
// entries, drained opportunistically. Optional macro WBUF_FORWARD_EN enables read forwarding.
module write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       c_read_en,
  input  logic                       c_write_en,
  input  logic [31:0]                c_addr,
  input  logic [31:0]                c_wdata,
  output logic [31:0]                c_rdata,
  output logic                       stall,
  output logic                       mem_write_en,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  input  logic [31:0]                mem_rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count_q;

  logic          hit;
  logic [PW-1:0] hit_idx;
  logic          match;
  logic          fwd;
  logic          port_need;
  logic          force_drain;
  logic          full;
  logic          drain;
  logic          head_hit;
  logic          alloc;
  logic          upd;

  // Stored addresses are unique, so at most one entry can hit.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == c_addr)) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
    end
  end

  assign match = hit & ~reset;

`ifdef WBUF_FORWARD_EN
  assign fwd         = c_read_en & match;
  assign port_need   = c_read_en & ~match;
  assign force_drain = 1'b0;
`else
  // A read hit must wait until the matching entry has reached memory.
  assign fwd         = 1'b0;
  assign port_need   = c_read_en;
  assign force_drain = c_read_en & match;
`endif

  assign full     = (count_q == CW'(DEPTH));
  assign drain    = ~reset & (count_q != '0) & (~port_need | full | force_drain);
  assign head_hit = drain & c_write_en & match & (hit_idx == head);
  assign alloc    = ~reset & c_write_en & ~match;
  assign upd      = ~reset & c_write_en & match & ~head_hit;

  assign mem_write_en = drain;
  assign mem_addr     = drain ? addr_q[head] : c_addr;
  assign mem_wdata    = head_hit ? c_wdata : data_q[head];
  assign stall        = c_read_en & port_need & drain;
  assign c_rdata      = fwd ? data_q[hit_idx] : mem_rdata;
  assign count        = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (drain) begin
        valid_q[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      // When full, the drained slot is the tail slot, so the allocation must win.
      if (alloc) begin
        valid_q[tail] <= 1'b1;
        tail          <= tail + 1'b1;
      end
      count_q <= count_q + CW'(alloc) - CW'(drain);
    end
  end

  // Payload needs no reset; valid_q gates every use of it.
  always_ff @(posedge clk) begin
    if (upd) begin
      data_q[hit_idx] <= c_wdata;
    end
    if (alloc) begin
      addr_q[tail] <= c_addr;
      data_q[tail] <= c_wdata;
    end
  end

endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer: a small memory model, a queue of expected memory
// writes checked as they appear, and per-cycle checks of count/stall/read data.
module tb_write_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          c_read_en;
  logic          c_write_en;
  logic [31:0]   c_addr;
  logic [31:0]   c_wdata;
  logic [31:0]   c_rdata;
  logic          stall;
  logic          mem_write_en;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [CW-1:0] count;

  logic [31:0] mem_arr [256];
  logic [63:0] exp_q [$];
  int          vec_cnt = 0;
  int          err_cnt = 0;

  write_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .c_read_en    (c_read_en),
    .c_write_en   (c_write_en),
    .c_addr       (c_addr),
    .c_wdata      (c_wdata),
    .c_rdata      (c_rdata),
    .stall        (stall),
    .mem_write_en (mem_write_en),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .count        (count)
  );

  // clock / reset
  always #5 clk = ~clk;

  // main memory model: combinational read, write on the rising edge
  assign mem_rdata = mem_arr[mem_addr[7:0]];
  always @(posedge clk) begin
    if (mem_write_en === 1'b1) mem_arr[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard: every memory write must match the head of the expected queue
  always @(negedge clk) begin
    if (mem_write_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("mem_wr_unexpected", {31'b0, mem_write_en}, 32'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("mem_wr_addr", mem_addr, e[63:32]);
        check("mem_wr_data", mem_wdata, e[31:0]);
      end
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic re, input logic we, input logic [31:0] a, input logic [31:0] d);
    c_read_en  = re;
    c_write_en = we;
    c_addr     = a;
    c_wdata    = d;
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  function automatic logic [31:0] cnt32();
    return 32'(count);
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'hA000_0000 | 32'(i);

    // reset: outputs idle even with a read pending
    reset = 1'b1;
    drive(1'b1, 1'b0, 32'h99, 32'h0);
    next_cycle();
    check("rst_count", cnt32(), 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_mwe", {31'b0, mem_write_en}, 32'd0);
    check("rst_maddr", mem_addr, 32'h99);
    check("rst_rdata", c_rdata, 32'hA000_0099);
    reset = 1'b0;

    // single write drains once idle
    drive(1'b0, 1'b1, 32'h10, 32'h11);
    push(32'h10, 32'h11);
    check("w1_mwe", {31'b0, mem_write_en}, 32'd0);
    check("w1_maddr", mem_addr, 32'h10);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("w1_count1", cnt32(), 32'd1);
    check("w1_drain", {31'b0, mem_write_en}, 32'd1);
    next_cycle();
    check("w1_count0", cnt32(), 32'd0);
    check("w1_idle", {31'b0, mem_write_en}, 32'd0);

    // rewrite of a buffered address overwrites in place
    drive(1'b0, 1'b1, 32'h21, 32'h7);
    push(32'h21, 32'h7);
    next_cycle();
    drive(1'b1, 1'b1, 32'h20, 32'h1);
    check("ow_count1", cnt32(), 32'd1);
    check("ow_miss_nostall", {31'b0, stall}, 32'd0);
    check("ow_miss_rdata", c_rdata, 32'hA000_0020);
    next_cycle();
    drive(1'b0, 1'b1, 32'h20, 32'h2);
    push(32'h20, 32'h2);
    check("ow_count2", cnt32(), 32'd2);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("ow_count_after", cnt32(), 32'd1);
    next_cycle();
    check("ow_count0", cnt32(), 32'd0);
    check("ow_mem", mem_arr[8'h20], 32'h2);

    // fill under read pressure; fifth write forces a drain and stalls the read
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b1, 32'h50 + 32'(i), 32'h150 + 32'(i));
      check("fill_count", cnt32(), 32'(i));
      check("fill_stall", {31'b0, stall}, 32'd0);
      check("fill_rdata", c_rdata, 32'hA000_0050 + 32'(i));
      next_cycle();
    end
    drive(1'b1, 1'b1, 32'h54, 32'h154);
    push(32'h50, 32'h150);
    check("full_count", cnt32(), 32'd4);
    check("full_stall", {31'b0, stall}, 32'd1);
    check("full_mwe", {31'b0, mem_write_en}, 32'd1);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 1; i <= 4; i++) push(32'h50 + 32'(i), 32'h150 + 32'(i));
    for (int k = 0; k <= 4; k++) begin
      check("full_drain_count", cnt32(), 32'(4 - k));
      next_cycle();
    end

    // read of a buffered address
    drive(1'b0, 1'b1, 32'h30, 32'hAB);
    push(32'h30, 32'hAB);
    next_cycle();
    drive(1'b1, 1'b0, 32'h30, 32'h0);
    check("rd_hit_count", cnt32(), 32'd1);
    check("rd_hit_mwe", {31'b0, mem_write_en}, 32'd1);
`ifdef WBUF_FORWARD_EN
    check("rd_hit_stall", {31'b0, stall}, 32'd0);
    check("rd_hit_fwd", c_rdata, 32'hAB);
    next_cycle();
`else
    check("rd_hit_stall", {31'b0, stall}, 32'd1);
    next_cycle();
    check("rd_retry_stall", {31'b0, stall}, 32'd0);
    check("rd_retry_rdata", c_rdata, 32'hAB);
`endif
    check("rd_hit_count0", cnt32(), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    next_cycle();

    // write hitting the draining head goes straight to memory
    drive(1'b0, 1'b1, 32'h40, 32'h5);
    next_cycle();
    drive(1'b0, 1'b1, 32'h40, 32'h6);
    push(32'h40, 32'h6);
    check("hd_count1", cnt32(), 32'd1);
    check("hd_mwdata", mem_wdata, 32'h6);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("hd_count0", cnt32(), 32'd0);
    check("hd_idle", {31'b0, mem_write_en}, 32'd0);
    next_cycle();

    // reset with pending entries discards them
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'h60 + 32'(i), 32'h160 + 32'(i));
      next_cycle();
    end
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("mr_count3", cnt32(), 32'd3);
    check("mr_mwe", {31'b0, mem_write_en}, 32'd0);
    check("mr_stall", {31'b0, stall}, 32'd0);
    next_cycle();
    reset = 1'b0;
    #1;
    check("mr_count0", cnt32(), 32'd0);
    for (int k = 0; k < 3; k++) begin
      check("mr_no_write", {31'b0, mem_write_en}, 32'd0);
      next_cycle();
    end
    check("mr_mem", mem_arr[8'h60], 32'hA000_0060);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/write_buffer.md
WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the number of buffered word writes (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port c_read_en, input, 1 bit: the cache requests a word read at c_addr.
REQ-005 SHALL have port c_write_en, input, 1 bit: the cache writes back a word, c_wdata to c_addr.
REQ-006 SHALL have port c_addr, input, 32 bits: word address from the cache (the cache's maddr).
REQ-007 SHALL have port c_wdata, input, 32 bits: write data from the cache (the cache's mdata).
REQ-008 SHALL have port c_rdata, output, 32 bits: read data returned to the cache (the cache's mout).
REQ-009 SHALL have port stall, output, 1 bit: the current request is not served; the cache holds all inputs.
REQ-010 SHALL have port mem_write_en, output, 1 bit: main-memory write strobe.
REQ-011 SHALL have port mem_addr, output, 32 bits: main-memory address.
REQ-012 SHALL have port mem_wdata, output, 32 bits: main-memory write data.
REQ-013 SHALL have port mem_rdata, input, 32 bits: main-memory combinational read data at mem_addr.
REQ-014 SHALL have port count, output, $clog2(DEPTH)+1 bits: number of occupied entries (inspection).

Function
REQ-015 SHALL hold entries as a circular FIFO (head, tail, count) with {addr, data} per entry; stored addresses are always unique.
REQ-016 SHALL define match as: an entry's address equals c_addr (at most one entry matches).
REQ-017 SHALL define port_need as c_read_en & no match, or c_read_en & match with WBUF_FORWARD_EN undefined.
REQ-018 SHALL assert drain when count!=0 & (!port_need | count==DEPTH | (c_read_en & match & WBUF_FORWARD_EN undefined)).
REQ-019 SHALL, on drain, drive mem_write_en=1, mem_addr=head.addr and mem_wdata=head.data, and retire the head at the edge.
REQ-020 SHALL, when there is no drain, drive mem_write_en=0 and mem_addr=c_addr.
REQ-021 SHALL assert stall = c_read_en & port_need & drain; the write path never stalls.
REQ-022 SHALL, on c_write_en with a match, overwrite that entry's data in place and leave count unchanged.
REQ-023 SHALL, on c_write_en without a match, allocate at tail; when count==DEPTH the same-cycle drain frees the slot, so count stays DEPTH.
REQ-024 SHALL, when a write matches the head while it drains, drive mem_wdata=c_wdata and retire the entry; it SHALL NOT allocate a new one.
REQ-025 SHALL make an accepted write visible to match and forwarding from the next cycle; a same-cycle read sees the pre-write contents.
REQ-026 SHALL drive c_rdata=mem_rdata when not forwarding; it is don't-care while stall=1.
REQ-027 SHALL wrap the head and tail pointers modulo DEPTH; count stays within 0..DEPTH.

Reset
REQ-028 SHALL, while reset=1, clear count, head and tail and invalidate all entries; it SHALL NOT issue any memory write that cycle.
REQ-029 SHALL hold these reset values of the outputs: count=0, stall=0, mem_write_en=0, mem_addr=c_addr, c_rdata=mem_rdata.
REQ-030 SHALL discard pending entries when reset is asserted mid-drain; memory keeps only writes completed at earlier edges.

Configuration
REQ-031 SHALL, with WBUF_FORWARD_EN defined, on a read that matches, drive c_rdata=entry.data with stall=0 in the same cycle; the port stays free for draining.
REQ-032 SHALL, with WBUF_FORWARD_EN undefined, stall a matching read and force drains until no match remains, then read memory.

Verification
REQ-033 SHALL cover: reset, then write A=0x10/D=0x11 with no reads for 2 cycles -> count 1 then 0; exactly one mem write 0x10<-0x11.
REQ-034 SHALL cover: write 0x20<-0x1, then write 0x20<-0x2, then drain -> count stays 1; memory receives only 0x2.
REQ-035 SHALL cover: DEPTH=4, continuous reads to a non-matching address plus 5 distinct writes -> 5th write is accepted with a forced drain; stall=1 that cycle; count=4.
REQ-036 SHALL cover: entry 0x30<-0xAB, read 0x30 -> with WBUF_FORWARD_EN, c_rdata=0xAB and stall=0; without it, stall=1 for 1 cycle, then c_rdata=0xAB from memory.
REQ-037 SHALL cover: 3 entries pending, reset for 1 cycle -> count=0 and no further mem_write_en pulses.
REQ-038 SHALL cover: single entry 0x40<-0x5 draining while write 0x40<-0x6 arrives -> one mem write 0x40<-0x6; count=0 afterwards.
